approx_mac: RTL and testbench

Pipelined, mode-selectable fixed-width approximate multiply-accumulate unit for DNN dot products. It is the sequential, parametrised successor to the combinational fixed-width JFM multiplier. It accepts a stream of unsigned operand pairs, forms a W-bit fixed-width product per pair (exact, plain-truncated or JFM-corrected), and accumulates the products of one vector. Each vector ends with a `last` beat and returns one sum over a valid/ready handshake.

---
 rtl/approx_mult_pkg.sv | 26 ++
 rtl/approx_mac_if.sv | 29 ++
 rtl/approx_fw_mult.sv | 57 +++++
 rtl/approx_mac.sv | 131 +++++++++++++
 tb/tb_approx_mac.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/approx_mult_pkg.sv
// Shared types and constants for the approximate fixed-width multiplier and MAC.
// Mode decode maps the reserved encoding onto JFM so nothing downstream sees it.
package approx_mult_pkg;

  typedef enum logic [1:0] {
    EXACT = 2'd0,
    TRUNC = 2'd1,
    JFM   = 2'd2
  } mult_mode_e;

  localparam int MAC_LATENCY = 3;

  function automatic mult_mode_e to_mode(input logic [1:0] m);
    case (m)
      2'd0:    return EXACT;
      2'd1:    return TRUNC;
      default: return JFM;
    endcase
  endfunction

  // Column W-1 is the highest discarded column; JFM keeps it as the correction term.
  function automatic int corr_col(input int w);
    return w - 1;
  endfunction

endpackage

// File: rtl/approx_mac_if.sv
// Operand stream in, vector sum out, each with its own valid/ready pair.
// The MAC is the slave; whoever feeds and drains it is the master.
interface approx_mac_if #(
  parameter int BITWIDTH = 8,
  parameter int ACC_W    = 2 * BITWIDTH
);

  logic                in_valid;
  logic                in_ready;
  logic [BITWIDTH-1:0] a;
  logic [BITWIDTH-1:0] b;
  logic                in_last;
  logic [1:0]          mode;
  logic                out_valid;
  logic                out_ready;
  logic [ACC_W-1:0]    out_sum;
  logic                out_ovf;

  modport master (
    output in_valid, a, b, in_last, mode, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, a, b, in_last, mode, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

endinterface

// File: rtl/approx_fw_mult.sv
// Combinational W-bit fixed-width multiplier: partial products, column masking,
// accumulation of the kept columns, then the upper W bits of the sum.
module approx_fw_mult
  import approx_mult_pkg::*;
#(
  parameter int BITWIDTH = 8
) (
  input  logic [BITWIDTH-1:0] a,
  input  logic [BITWIDTH-1:0] b,
  input  mult_mode_e          mode,
  output logic [BITWIDTH-1:0] p
);

  localparam int PW = 2 * BITWIDTH;

  logic [BITWIDTH-1:0][BITWIDTH-1:0] pp;
  logic [PW-1:0]                     col_keep;
  logic [PW-1:0]                     kept_sum;
  int                                keep_from;

  always_comb begin
    for (int i = 0; i < BITWIDTH; i++) begin
      for (int j = 0; j < BITWIDTH; j++) begin
        pp[i][j] = a[i] & b[j];
      end
    end
  end

  always_comb begin
    case (mode)
      EXACT:   keep_from = 0;
      TRUNC:   keep_from = BITWIDTH;
      default: keep_from = corr_col(BITWIDTH);
    endcase
  end

  always_comb begin
    for (int c = 0; c < PW; c++) begin
      col_keep[c] = (c >= keep_from);
    end
  end

  // pp(i,j) carries weight 2^(i+j); only columns at or above keep_from contribute.
  always_comb begin
    kept_sum = '0;
    for (int i = 0; i < BITWIDTH; i++) begin
      for (int j = 0; j < BITWIDTH; j++) begin
        if (col_keep[i+j]) begin
          kept_sum = kept_sum + (PW'(pp[i][j]) << (i + j));
        end
      end
    end
  end

  assign p = BITWIDTH'(kept_sum >> BITWIDTH);

endmodule

// File: rtl/approx_mac.sv
// Three-stage approximate MAC: operand register, fixed-width product register,
// accumulator with per-vector mode latch, overflow tracking and output handshake.
module approx_mac
  import approx_mult_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int ACC_W    = 2 * BITWIDTH,
  parameter bit SATURATE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  approx_mac_if.slave  bus
);

  logic                advance;
  logic                accept;
  logic                first_flag;
  mult_mode_e          vec_mode;
  mult_mode_e          beat_mode;

  logic                s1_valid;
  logic [BITWIDTH-1:0] s1_a;
  logic [BITWIDTH-1:0] s1_b;
  logic                s1_last;
  logic                s1_first;
  mult_mode_e          s1_mode;
  logic [BITWIDTH-1:0] prod;

  logic                s2_valid;
  logic [BITWIDTH-1:0] s2_prod;
  logic                s2_last;
  logic                s2_first;

  logic [ACC_W-1:0]    acc_q;
  logic                ovf_q;
  logic [ACC_W:0]      sum_ext;
  logic [ACC_W-1:0]    acc_next;
  logic                ovf_next;

  logic                out_valid_q;
  logic [ACC_W-1:0]    out_sum_q;
  logic                out_ovf_q;

  // A held result freezes the whole pipe; in_ready never looks at in_valid.
  assign advance      = !(out_valid_q && !bus.out_ready);
  assign accept       = bus.in_valid && advance;
  assign bus.in_ready = advance;

  assign beat_mode = first_flag ? to_mode(bus.mode) : vec_mode;

  approx_fw_mult #(
    .BITWIDTH(BITWIDTH)
  ) u_mult (
    .a    (s1_a),
    .b    (s1_b),
    .mode (s1_mode),
    .p    (prod)
  );

  assign sum_ext = {1'b0, acc_q} + (ACC_W + 1)'(s2_prod);

  always_comb begin
    acc_next = acc_q;
    ovf_next = ovf_q;
    if (s2_first) begin
      acc_next = ACC_W'(s2_prod);
      ovf_next = 1'b0;
    end else if (sum_ext[ACC_W]) begin
      acc_next = SATURATE ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
      ovf_next = 1'b1;
    end else begin
      acc_next = sum_ext[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_flag  <= 1'b1;
      vec_mode    <= EXACT;
      s1_valid    <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_last     <= 1'b0;
      s1_first    <= 1'b0;
      s1_mode     <= EXACT;
      s2_valid    <= 1'b0;
      s2_prod     <= '0;
      s2_last     <= 1'b0;
      s2_first    <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else if (advance) begin
      if (accept) begin
        first_flag <= bus.in_last;
        if (first_flag) vec_mode <= to_mode(bus.mode);
        s1_a     <= bus.a;
        s1_b     <= bus.b;
        s1_last  <= bus.in_last;
        s1_first <= first_flag;
        s1_mode  <= beat_mode;
      end
      s1_valid <= accept;

      if (s1_valid) begin
        s2_prod  <= prod;
        s2_last  <= s1_last;
        s2_first <= s1_first;
      end
      s2_valid <= s1_valid;

      // advance implies any pending result is consumed on this edge
      if (s2_valid) begin
        acc_q <= acc_next;
        ovf_q <= ovf_next;
        if (s2_last) begin
          out_sum_q <= acc_next;
          out_ovf_q <= ovf_next;
        end
      end
      out_valid_q <= s2_valid && s2_last;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_approx_mac.sv
// Directed bench for approx_mac: vector table plus stall, back-to-back,
// saturation/wrap and mid-vector reset sequences.
module tb_approx_mac;
  import approx_mult_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  approx_mac_if #(.BITWIDTH(8), .ACC_W(16)) bus ();
  approx_mac_if #(.BITWIDTH(8), .ACC_W(8))  bus_sat ();
  approx_mac_if #(.BITWIDTH(8), .ACC_W(8))  bus_wrap ();

  // The narrow-accumulator instances mirror the main stimulus.
  assign bus_sat.in_valid   = bus.in_valid;
  assign bus_sat.a          = bus.a;
  assign bus_sat.b          = bus.b;
  assign bus_sat.in_last    = bus.in_last;
  assign bus_sat.mode       = bus.mode;
  assign bus_sat.out_ready  = bus.out_ready;
  assign bus_wrap.in_valid  = bus.in_valid;
  assign bus_wrap.a         = bus.a;
  assign bus_wrap.b         = bus.b;
  assign bus_wrap.in_last   = bus.in_last;
  assign bus_wrap.mode      = bus.mode;
  assign bus_wrap.out_ready = bus.out_ready;

  approx_mac #(.BITWIDTH(8), .ACC_W(16), .SATURATE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  approx_mac #(.BITWIDTH(8), .ACC_W(8), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus_sat));
  approx_mac #(.BITWIDTH(8), .ACC_W(8), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(bus_wrap));

  typedef struct packed {
    logic [2:0]       len;
    logic [3:0][1:0]  modes;
    logic [3:0][7:0]  av;
    logic [3:0][7:0]  bv;
    logic [15:0]      exp_sum;
    logic             exp_ovf;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  int tests_run    = 0;
  int tests_failed = 0;

  function automatic vec_t mk(input logic [2:0] len, input logic [3:0][1:0] modes,
                              input logic [3:0][7:0] av, input logic [3:0][7:0] bv,
                              input logic [15:0] exp_sum);
    vec_t v;
    v.len     = len;
    v.modes   = modes;
    v.av      = av;
    v.bv      = bv;
    v.exp_sum = exp_sum;
    v.exp_ovf = 1'b0;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the beat is taken.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic last, input logic [1:0] mode);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.in_last  = last;
    bus.mode     = mode;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) checkOutput("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic waitResult();
    int n = 0;
    while (!bus.out_valid && n < 30) begin
      tick();
      n++;
    end
    if (!bus.out_valid) checkOutput("out_valid_timeout", {31'd0, bus.out_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] bb_exp [4];
    logic [1:0]  bb_mode [4];
    logic [7:0]  bb_a [4];
    logic [7:0]  bb_b [4];

    // Packed lists read element 3 first, element 0 last.
    vecs[0]  = mk(1, {2'd0, 2'd0, 2'd0, 2'd0}, {8'h00, 8'h00, 8'h00, 8'hFF}, {8'h00, 8'h00, 8'h00, 8'hFF}, 16'd254);
    vecs[1]  = mk(1, {2'd0, 2'd0, 2'd0, 2'd1}, {8'h00, 8'h00, 8'h00, 8'hFF}, {8'h00, 8'h00, 8'h00, 8'hFF}, 16'd247);
    vecs[2]  = mk(1, {2'd0, 2'd0, 2'd0, 2'd2}, {8'h00, 8'h00, 8'h00, 8'hFF}, {8'h00, 8'h00, 8'h00, 8'hFF}, 16'd251);
    vecs[3]  = mk(1, {2'd0, 2'd0, 2'd0, 2'd3}, {8'h00, 8'h00, 8'h00, 8'hFF}, {8'h00, 8'h00, 8'h00, 8'hFF}, 16'd251);
    vecs[4]  = mk(3, {2'd0, 2'd0, 2'd0, 2'd2}, {8'h00, 8'h10, 8'hFF, 8'h80}, {8'h00, 8'h10, 8'hFF, 8'h80}, 16'd316);
    vecs[5]  = mk(2, {2'd0, 2'd0, 2'd0, 2'd0}, {8'h00, 8'h00, 8'hAB, 8'h12}, {8'h00, 8'h00, 8'hCD, 8'h34}, 16'd139);
    vecs[6]  = mk(1, {2'd0, 2'd0, 2'd0, 2'd0}, {8'h00, 8'h00, 8'h00, 8'hF0}, {8'h00, 8'h00, 8'h00, 8'h0F}, 16'd14);
    vecs[7]  = mk(1, {2'd0, 2'd0, 2'd0, 2'd1}, {8'h00, 8'h00, 8'h00, 8'hF0}, {8'h00, 8'h00, 8'h00, 8'h0F}, 16'd11);
    vecs[8]  = mk(1, {2'd0, 2'd0, 2'd0, 2'd2}, {8'h00, 8'h00, 8'h00, 8'hF0}, {8'h00, 8'h00, 8'h00, 8'h0F}, 16'd13);
    vecs[9]  = mk(1, {2'd0, 2'd0, 2'd0, 2'd0}, {8'h00, 8'h00, 8'h00, 8'h00}, {8'h00, 8'h00, 8'h00, 8'hFF}, 16'd0);
    vecs[10] = mk(4, {2'd2, 2'd2, 2'd2, 2'd2}, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 16'd1004);
    vecs[11] = mk(2, {2'd0, 2'd0, 2'd2, 2'd1}, {8'h00, 8'h00, 8'hFF, 8'hFF}, {8'h00, 8'h00, 8'hFF, 8'hFF}, 16'd494);

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.in_last   = 1'b0;
    bus.mode      = 2'd0;
    bus.out_ready = 1'b1;

    #1;
    checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rst_out_sum", {16'd0, bus.out_sum}, 32'd0);
    checkOutput("rst_out_ovf", {31'd0, bus.out_ovf}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    #21;
    rst_n = 1'b1;
    tick();

    // Latency: the accepting edge counts as the first of MAC_LATENCY edges.
    applyStimulus(8'hFF, 8'hFF, 1'b1, 2'd0);
    for (int e = 1; e < MAC_LATENCY; e++) begin
      checkOutput($sformatf("latency_edge%0d_low", e), {31'd0, bus.out_valid}, 32'd0);
      tick();
    end
    checkOutput("latency_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("latency_sum", {16'd0, bus.out_sum}, 32'd254);
    tick();

    for (int i = 0; i < NVEC; i++) begin
      for (int k = 0; k < int'(vecs[i].len); k++) begin
        applyStimulus(vecs[i].av[k], vecs[i].bv[k], (k == int'(vecs[i].len) - 1), vecs[i].modes[k]);
      end
      waitResult();
      checkOutput($sformatf("vec%0d_sum", i), {16'd0, bus.out_sum}, {16'd0, vecs[i].exp_sum});
      checkOutput($sformatf("vec%0d_ovf", i), {31'd0, bus.out_ovf}, {31'd0, vecs[i].exp_ovf});
    end
    repeat (3) tick();

    // Saturation and wrap on the 8-bit accumulators; the 16-bit one must not overflow.
    for (int k = 0; k < 3; k++) applyStimulus(8'hFF, 8'hFF, (k == 2), 2'd0);
    waitResult();
    checkOutput("ovf_main_sum", {16'd0, bus.out_sum}, 32'd762);
    checkOutput("ovf_main_flag", {31'd0, bus.out_ovf}, 32'd0);
    checkOutput("sat_valid", {31'd0, bus_sat.out_valid}, 32'd1);
    checkOutput("sat_sum", {24'd0, bus_sat.out_sum}, 32'd255);
    checkOutput("sat_flag", {31'd0, bus_sat.out_ovf}, 32'd1);
    checkOutput("wrap_sum", {24'd0, bus_wrap.out_sum}, 32'd250);
    checkOutput("wrap_flag", {31'd0, bus_wrap.out_ovf}, 32'd1);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 2'd0);
    waitResult();
    checkOutput("sat_next_sum", {24'd0, bus_sat.out_sum}, 32'd254);
    checkOutput("sat_next_flag", {31'd0, bus_sat.out_ovf}, 32'd0);
    checkOutput("wrap_next_flag", {31'd0, bus_wrap.out_ovf}, 32'd0);
    checkOutput("wrap_in_ready", {31'd0, bus_wrap.in_ready & bus_sat.in_ready}, 32'd1);
    repeat (3) tick();

    // Stall: vector A held for five cycles while vector B streams in behind it.
    bus.out_ready = 1'b0;
    fork
      begin
        applyStimulus(8'hFF, 8'hFF, 1'b0, 2'd2);
        applyStimulus(8'h80, 8'h80, 1'b1, 2'd0);
        applyStimulus(8'h12, 8'h34, 1'b0, 2'd0);
        applyStimulus(8'hAB, 8'hCD, 1'b1, 2'd2);
      end
      begin
        waitResult();
        for (int c = 0; c < 5; c++) begin
          checkOutput($sformatf("stall%0d_in_ready", c), {31'd0, bus.in_ready}, 32'd0);
          checkOutput($sformatf("stall%0d_sum", c), {16'd0, bus.out_sum}, 32'd315);
          checkOutput($sformatf("stall%0d_valid", c), {31'd0, bus.out_valid}, 32'd1);
          tick();
        end
        bus.out_ready = 1'b1;
        checkOutput("stall_release_sum", {16'd0, bus.out_sum}, 32'd315);
        tick();
        waitResult();
        checkOutput("stall_second_sum", {16'd0, bus.out_sum}, 32'd139);
        checkOutput("stall_second_ovf", {31'd0, bus.out_ovf}, 32'd0);
      end
    join
    repeat (3) tick();

    // Back-to-back single-beat vectors: one result per cycle, none accumulated.
    bb_exp  = '{16'd254, 16'd11, 16'd64, 16'd3};
    bb_mode = '{2'd0, 2'd1, 2'd2, 2'd0};
    bb_a    = '{8'hFF, 8'hF0, 8'h80, 8'h12};
    bb_b    = '{8'hFF, 8'h0F, 8'h80, 8'h34};
    fork
      begin
        for (int k = 0; k < 4; k++) applyStimulus(bb_a[k], bb_b[k], 1'b1, bb_mode[k]);
      end
      begin
        waitResult();
        for (int k = 0; k < 4; k++) begin
          checkOutput($sformatf("b2b%0d_valid", k), {31'd0, bus.out_valid}, 32'd1);
          checkOutput($sformatf("b2b%0d_sum", k), {16'd0, bus.out_sum}, {16'd0, bb_exp[k]});
          tick();
        end
      end
    join
    repeat (3) tick();

    // Mid-vector reset with a held result and a half-finished vector in flight.
    bus.out_ready = 1'b0;
    applyStimulus(8'hFF, 8'hFF, 1'b1, 2'd0);
    applyStimulus(8'h80, 8'h80, 1'b0, 2'd2);
    waitResult();
    checkOutput("prereset_sum", {16'd0, bus.out_sum}, 32'd254);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("midrst_out_sum", {16'd0, bus.out_sum}, 32'd0);
    checkOutput("midrst_out_ovf", {31'd0, bus.out_ovf}, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    applyStimulus(8'hF0, 8'h0F, 1'b1, 2'd1);
    waitResult();
    checkOutput("postrst_sum", {16'd0, bus.out_sum}, 32'd11);
    checkOutput("postrst_ovf", {31'd0, bus.out_ovf}, 32'd0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
